// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle produced by vga_timing_gen and consumed by the colour stage.
interface vga_timing_gen_if;
    logic       pix_en;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       line_tick;
    logic       frame_tick;

    modport master (
        output pix_en, hCount, vCount, hSync, vSync, bright, line_tick, frame_tick
    );

    modport slave (
        input  pix_en, hCount, vCount, hSync, vSync, bright, line_tick, frame_tick
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-rate divider, h/v counters, and sync/visible/tick
// decodes registered together with the counters so they never lag a pixel.
module vga_timing_gen #(
    parameter int CLK_DIV      = 4,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC       = 96,
    parameter int H_DISP_START = 144,
    parameter int H_DISP_END   = 784,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC       = 2,
    parameter int V_DISP_START = 35,
    parameter int V_DISP_END   = 515
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  vga_o
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_SYNC_C = 10'(H_SYNC);
    localparam logic [9:0]       V_SYNC_C = 10'(V_SYNC);
    localparam logic [9:0]       H_DS     = 10'(H_DISP_START);
    localparam logic [9:0]       H_DE     = 10'(H_DISP_END);
    localparam logic [9:0]       V_DS     = 10'(V_DISP_START);
    localparam logic [9:0]       V_DE     = 10'(V_DISP_END);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             pix_en_q, pix_en_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             bright_q, bright_d;
    logic             line_tick_q, line_tick_d;
    logic             frame_tick_q, frame_tick_d;
    logic             div_wrap_s;

    // Next-state: counters advance only on divider wrap; decodes use the next counts.
    always_comb begin
        div_wrap_s   = (div_q == DIV_LAST);
        div_d        = div_q;
        h_d          = h_q;
        v_d          = v_q;
        pix_en_d     = 1'b0;
        line_tick_d  = 1'b0;
        frame_tick_d = 1'b0;
        if (div_wrap_s) begin
            div_d    = {DIV_W{1'b0}};
            pix_en_d = 1'b1;
            if (h_q == H_LAST) begin
                h_d         = 10'd0;
                line_tick_d = 1'b1;
                if (v_q == V_LAST) begin
                    v_d          = 10'd0;
                    frame_tick_d = 1'b1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        // Decoding from the next counts keeps syncs/bright aligned with hCount/vCount.
        hsync_d  = (h_d >= H_SYNC_C);
        vsync_d  = (v_d >= V_SYNC_C);
        bright_d = (h_d >= H_DS) && (h_d < H_DE) && (v_d >= V_DS) && (v_d < V_DE);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q        <= {DIV_W{1'b0}};
            h_q          <= 10'd0;
            v_q          <= 10'd0;
            pix_en_q     <= 1'b0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            bright_q     <= 1'b0;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            h_q          <= h_d;
            v_q          <= v_d;
            pix_en_q     <= pix_en_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            bright_q     <= bright_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vga_o.pix_en     = pix_en_q;
    assign vga_o.hCount     = h_q;
    assign vga_o.vCount     = v_q;
    assign vga_o.hSync      = hsync_q;
    assign vga_o.vSync      = vsync_q;
    assign vga_o.bright     = bright_q;
    assign vga_o.line_tick  = line_tick_q;
    assign vga_o.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default build, a short-frame build (default line, 6 lines)
// and a CLK_DIV=1 miniature build, all on one clock with independent resets.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst0, rstv, rsts;
    always #5 clk = ~clk;

    vga_timing_gen_if if0 ();
    vga_timing_gen_if ifv ();
    vga_timing_gen_if ifs ();

    vga_timing_gen u0 (.clk(clk), .rst(rst0), .vga_o(if0));

    vga_timing_gen #(
        .V_TOTAL(6), .V_SYNC(2), .V_DISP_START(3), .V_DISP_END(5)
    ) uv (.clk(clk), .rst(rstv), .vga_o(ifv));

    vga_timing_gen #(
        .CLK_DIV(1), .H_TOTAL(10), .H_SYNC(2), .H_DISP_START(3), .H_DISP_END(8),
        .V_TOTAL(4), .V_SYNC(1), .V_DISP_START(1), .V_DISP_END(3)
    ) us (.clk(clk), .rst(rsts), .vga_o(ifs));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int k;
        int pe, h, v, hs, vs, br, lt, ft;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int k, first, second, hs_low, pe_cnt, br_cnt, bad, v0, found;
        int seen, falls, bright_pix, br_out, vs_low, early_ft, prev_br, kft, lt_cnt;
        int pe0, lt_n, lt_first, ft_n, ft_first, ft_second;
        int hseq [3];
        int vseq [3];
        int ltseq [3];

        // {edge after release, pix_en, hCount, vCount, hSync, vSync, bright, line_tick, frame_tick}
        tbl[0]  = '{1,    0, 0,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{3,    0, 0,   0, 0, 0, 0, 0, 0};
        tbl[2]  = '{4,    1, 1,   0, 0, 0, 0, 0, 0};
        tbl[3]  = '{5,    0, 1,   0, 0, 0, 0, 0, 0};
        tbl[4]  = '{383,  0, 95,  0, 0, 0, 0, 0, 0};
        tbl[5]  = '{384,  1, 96,  0, 1, 0, 0, 0, 0};
        tbl[6]  = '{576,  1, 144, 0, 1, 0, 0, 0, 0};
        tbl[7]  = '{3196, 1, 799, 0, 1, 0, 0, 0, 0};
        tbl[8]  = '{3200, 1, 0,   1, 0, 0, 0, 1, 0};
        tbl[9]  = '{3201, 0, 0,   1, 0, 0, 0, 0, 0};
        tbl[10] = '{6400, 1, 0,   2, 0, 1, 0, 1, 0};
        tbl[11] = '{6404, 1, 1,   2, 0, 1, 0, 0, 0};

        rst0 = 1'b0;
        rstv = 1'b0;
        rsts = 1'b0;

        // Reset held for 10 clocks: every output of every build stays at zero.
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if ({if0.pix_en, if0.hCount, if0.vCount, if0.hSync, if0.vSync,
                 if0.bright, if0.line_tick, if0.frame_tick} != 26'd0) bad++;
            if ({ifv.pix_en, ifv.hCount, ifv.vCount, ifv.hSync, ifv.vSync,
                 ifv.bright, ifv.line_tick, ifv.frame_tick} != 26'd0) bad++;
        end
        chk("reset_hold_nonzero_samples", bad, 0);

        @(negedge clk);
        rst0 = 1'b1;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            while (k < tbl[i].k) begin
                step();
                k++;
            end
            chk($sformatf("vec%0d_pix_en", i),     int'(if0.pix_en),     tbl[i].pe);
            chk($sformatf("vec%0d_hCount", i),     int'(if0.hCount),     tbl[i].h);
            chk($sformatf("vec%0d_vCount", i),     int'(if0.vCount),     tbl[i].v);
            chk($sformatf("vec%0d_hSync", i),      int'(if0.hSync),      tbl[i].hs);
            chk($sformatf("vec%0d_vSync", i),      int'(if0.vSync),      tbl[i].vs);
            chk($sformatf("vec%0d_bright", i),     int'(if0.bright),     tbl[i].br);
            chk($sformatf("vec%0d_line_tick", i),  int'(if0.line_tick),  tbl[i].lt);
            chk($sformatf("vec%0d_frame_tick", i), int'(if0.frame_tick), tbl[i].ft);
        end

        // One full line of the default build between two line_ticks.
        first = -1; second = -1; hs_low = 0; pe_cnt = 0; br_cnt = 0;
        for (int n = 0; n < 8000 && second < 0; n++) begin
            step();
            k++;
            if (if0.line_tick) begin
                if (first < 0) first = k;
                else second = k;
            end
            if (first >= 0 && second < 0) begin
                if (!if0.hSync) hs_low++;
                if (if0.pix_en) pe_cnt++;
                if (if0.bright) br_cnt++;
            end
        end
        chk("line_tick_period", second - first, 3200);
        chk("hsync_low_clks_per_line", hs_low, 384);
        chk("pix_en_per_line", pe_cnt, 800);
        chk("bright_low_top_lines", br_cnt, 0);

        // hCount 797 -> 798 -> 799 -> 0 with vCount stepping at the wrap.
        found = 0; v0 = 0;
        for (int n = 0; n < 4000 && found == 0; n++) begin
            step();
            if (if0.pix_en && if0.hCount == 10'd797) begin
                found = 1;
                v0 = int'(if0.vCount);
            end
        end
        chk("found_h797", found, 1);
        for (int j = 0; j < 3; j++) begin
            hseq[j] = -1; vseq[j] = -1; ltseq[j] = -1;
            for (int n = 0; n < 8; n++) begin
                step();
                if (if0.pix_en) begin
                    hseq[j] = int'(if0.hCount);
                    vseq[j] = int'(if0.vCount);
                    ltseq[j] = int'(if0.line_tick);
                    break;
                end
            end
        end
        chk("hseq_798", hseq[0], 798);
        chk("hseq_799", hseq[1], 799);
        chk("hseq_wrap0", hseq[2], 0);
        chk("v_before_wrap", vseq[1], v0);
        chk("v_after_wrap", vseq[2], v0 + 1);
        chk("line_tick_at_wrap", ltseq[2], 1);

        // Short-frame build: one whole frame (6 lines x 3200 clks) after release.
        @(negedge clk);
        rstv = 1'b1;
        seen = 0; falls = 0; bright_pix = 0; br_out = 0; vs_low = 0; early_ft = 0; prev_br = 0;
        for (int n = 1; n <= 19200; n++) begin
            step();
            if (!seen && ifv.bright) begin
                seen = 1;
                chk("bright_first_h", int'(ifv.hCount), 144);
                chk("bright_first_v", int'(ifv.vCount), 3);
            end
            if (prev_br && !ifv.bright) begin
                falls++;
                chk($sformatf("bright_fall%0d_h", falls), int'(ifv.hCount), 784);
            end
            prev_br = int'(ifv.bright);
            if (ifv.pix_en && ifv.bright) bright_pix++;
            if (ifv.bright && (ifv.vCount < 10'd3 || ifv.vCount >= 10'd5)) br_out++;
            if (!ifv.vSync) vs_low++;
            if (ifv.frame_tick && n < 19200) early_ft++;
            if (n == 19199) begin
                chk("frame_end_h", int'(ifv.hCount), 799);
                chk("frame_end_v", int'(ifv.vCount), 5);
            end
        end
        chk("bright_seen", seen, 1);
        chk("bright_falls", falls, 2);
        chk("bright_pixels_per_frame", bright_pix, 1280);
        chk("bright_outside_window", br_out, 0);
        chk("vsync_low_clks_per_frame", vs_low, 6400);
        chk("frame_tick_early", early_ft, 0);
        chk("frame_tick_at_wrap", int'(ifv.frame_tick), 1);
        chk("line_tick_with_frame", int'(ifv.line_tick), 1);
        chk("wrap_h0", int'(ifv.hCount), 0);
        chk("wrap_v0", int'(ifv.vCount), 0);
        step();
        chk("frame_tick_one_clk", int'(ifv.frame_tick), 0);

        // Mid-frame asynchronous reset at hCount=400, vCount=2.
        found = 0;
        for (int n = 0; n < 20000 && found == 0; n++) begin
            step();
            if (ifv.hCount == 10'd400 && ifv.vCount == 10'd2) found = 1;
        end
        chk("found_h400_v2", found, 1);
        #2;
        rstv = 1'b0;
        #1;
        chk("async_rst_fields_nonzero",
            int'({ifv.pix_en, ifv.hCount, ifv.vCount, ifv.hSync, ifv.vSync,
                  ifv.bright, ifv.line_tick, ifv.frame_tick} != 26'd0), 0);
        chk("async_rst_hCount", int'(ifv.hCount), 0);
        repeat (3) step();
        @(negedge clk);
        rstv = 1'b1;
        kft = -1; lt_cnt = 0;
        for (int n = 1; n <= 20000 && kft < 0; n++) begin
            step();
            if (n == 4) chk("restart_h_at_edge4", int'(ifv.hCount), 1);
            if (ifv.frame_tick) kft = n;
            else if (ifv.line_tick) lt_cnt++;
        end
        chk("frame_tick_after_reset", kft, 19200);
        chk("line_ticks_before_frame", lt_cnt, 5);

        // CLK_DIV=1 miniature build: 10 pixels x 4 lines.
        @(negedge clk);
        rsts = 1'b1;
        pe0 = 0; lt_n = 0; lt_first = -1; ft_n = 0; ft_first = -1; ft_second = -1;
        for (int n = 1; n <= 100; n++) begin
            step();
            if (!ifs.pix_en) pe0++;
            if (ifs.line_tick) begin
                lt_n++;
                if (lt_first < 0) lt_first = n;
            end
            if (ifs.frame_tick) begin
                ft_n++;
                if (ft_first < 0) ft_first = n;
                else if (ft_second < 0) ft_second = n;
            end
            if (n == 9) chk("mini_h_edge9", int'(ifs.hCount), 9);
            if (n == 10) chk("mini_v_edge10", int'(ifs.vCount), 1);
        end
        chk("mini_pix_en_low_samples", pe0, 0);
        chk("mini_line_ticks", lt_n, 10);
        chk("mini_first_line_tick", lt_first, 10);
        chk("mini_frame_ticks", ft_n, 2);
        chk("mini_first_frame_tick", ft_first, 40);
        chk("mini_frame_period", ft_second - ft_first, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
